// File: rtl/viola_mem_pkg.sv
// Shared types and constants for the memory controller.
package viola_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_READ    = 2'd1,
        ST_WRITE   = 2'd2,
        ST_IO_WAIT = 2'd3
    } mem_state_e;

    localparam logic [1:0]  SIZE_BYTE = 2'b00;
    localparam logic [1:0]  SIZE_HALF = 2'b01;
    localparam logic [1:0]  SIZE_WORD = 2'b10;

    localparam logic [31:0] IO_BASE_DEFAULT = 32'h0003_0000;

    // One-hot grant bit positions.
    localparam int GNT_IF  = 0;
    localparam int GNT_LSB = 1;

    // Bytes moved for an LSB size code; the reserved code 11 is a word.
    function automatic logic [2:0] byte_count(input logic [1:0] size);
        case (size)
            SIZE_BYTE: byte_count = 3'd1;
            SIZE_HALF: byte_count = 3'd2;
            default:   byte_count = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_arb.sv
// Two-way arbiter between instruction fetch and the load/store buffer.
// MEM_CTRL_FAIR_EN selects round-robin; otherwise LSB always wins a tie.
module mem_arb
    import viola_mem_pkg::*;
(
`ifdef MEM_CTRL_FAIR_EN
    input  logic       clk,
    input  logic       rst_n,
`endif
    input  logic       req_if_i,
    input  logic       req_lsb_i,
    output logic [1:0] gnt_o
);

`ifdef MEM_CTRL_FAIR_EN
    logic last_lsb_q;

    // Remember which side was served last; reset favours LSB on the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            last_lsb_q <= 1'b0;
        else if (|gnt_o)
            last_lsb_q <= gnt_o[GNT_LSB];
    end

    // On a tie grant the side that did not win last time.
    always_comb begin
        gnt_o = '0;
        if (req_if_i && req_lsb_i) begin
            if (last_lsb_q)
                gnt_o[GNT_IF] = 1'b1;
            else
                gnt_o[GNT_LSB] = 1'b1;
        end else begin
            gnt_o[GNT_IF]  = req_if_i;
            gnt_o[GNT_LSB] = req_lsb_i;
        end
    end
`else
    // Fixed priority: LSB beats IF.
    always_comb begin
        gnt_o          = '0;
        gnt_o[GNT_LSB] = req_lsb_i;
        gnt_o[GNT_IF]  = req_if_i && !req_lsb_i;
    end
`endif

endmodule

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller shared by instruction fetch and the LSB.
// Build option: MEM_CTRL_FAIR_EN enables round-robin arbitration.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting; grants a pending request and issues its first byte
// READ     | issuing byte k, capturing byte k-1 from mem_din
// WRITE    | writing byte k of the store data
// IO_WAIT  | IO store held off until io_buffer_full drops
module mem_ctrl
    import viola_mem_pkg::*;
#(
    parameter int                ADDR_W  = 32,
    parameter logic [ADDR_W-1:0] IO_BASE = ADDR_W'(IO_BASE_DEFAULT)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pause,
    input  logic              flush,
    input  logic              io_buffer_full,
    input  logic [7:0]        mem_din,
    output logic [7:0]        mem_dout,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr,
    input  logic              if_asking,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [31:0]       if_data,
    output logic              if_ready,
    input  logic              lsb_valid,
    input  logic              lsb_wr,
    input  logic [1:0]        lsb_size,
    input  logic [ADDR_W-1:0] lsb_addr,
    input  logic [31:0]       lsb_wdata,
    output logic [31:0]       lsb_rdata,
    output logic              lsb_ready
);

    mem_state_e        state_q, state_d;
    logic [2:0]        k_q, k_d;
    logic              cur_lsb_q, cur_lsb_d;
    logic              replay_q, replay_d;
    logic [31:0]       buf_q, buf_d;

    logic              if_pend_q, if_pend_d;
    logic [ADDR_W-1:0] if_addr_q, if_addr_d;
    logic              lsb_pend_q, lsb_pend_d;
    logic              lsb_wr_q, lsb_wr_d;
    logic [1:0]        lsb_size_q, lsb_size_d;
    logic [ADDR_W-1:0] lsb_addr_q, lsb_addr_d;
    logic [31:0]       lsb_wdata_q, lsb_wdata_d;

    logic [31:0]       if_data_q, lsb_rdata_q;
    logic              if_ready_q, lsb_ready_q;

    logic              grant_en, req_if, req_lsb;
    logic [1:0]        gnt;
    logic              sel_lsb;
    logic [ADDR_W-1:0] base;
    logic [2:0]        nbytes;
    logic [1:0]        lane;
    logic              done_if, done_lsb;
    logic [31:0]       rdata_fin;

    // A flushed fetch must not be granted in the flush cycle itself.
    assign grant_en = (state_q == ST_IDLE) && !pause;
    assign req_if   = if_pend_q && !flush && grant_en;
    assign req_lsb  = lsb_pend_q && grant_en;

    mem_arb u_arb (
`ifdef MEM_CTRL_FAIR_EN
        .clk       (clk),
        .rst_n     (rst_n),
`endif
        .req_if_i  (req_if),
        .req_lsb_i (req_lsb),
        .gnt_o     (gnt)
    );

    // Transaction fields come straight from the owner's pending registers.
    assign sel_lsb = (state_q == ST_IDLE) ? gnt[GNT_LSB] : cur_lsb_q;
    assign base    = sel_lsb ? lsb_addr_q : if_addr_q;
    assign nbytes  = sel_lsb ? byte_count(lsb_size_q) : 3'd4;
    assign lane    = 2'(k_q - 3'd1);

    // Next-state, bus drive and byte assembly; pause freezes everything.
    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        cur_lsb_d = cur_lsb_q;
        replay_d  = replay_q;
        buf_d     = buf_q;
        mem_a     = '0;
        mem_dout  = '0;
        mem_wr    = 1'b0;
        done_if   = 1'b0;
        done_lsb  = 1'b0;
        rdata_fin = buf_q;
        if (pause) begin
            if (state_q == ST_READ)
                replay_d = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (|gnt) begin
                        cur_lsb_d = gnt[GNT_LSB];
                        k_d       = 3'd1;
                        buf_d     = '0;
                        mem_a     = base;
                        if (gnt[GNT_LSB] && lsb_wr_q) begin
                            if (lsb_addr_q >= IO_BASE && io_buffer_full) begin
                                state_d = ST_IO_WAIT;
                                k_d     = 3'd0;
                            end else begin
                                mem_wr   = 1'b1;
                                mem_dout = lsb_wdata_q[7:0];
                                if (nbytes == 3'd1)
                                    done_lsb = 1'b1;
                                else
                                    state_d = ST_WRITE;
                            end
                        end else begin
                            state_d = ST_READ;
                        end
                    end
                end
                ST_READ: begin
                    if (flush && !cur_lsb_q) begin
                        state_d = ST_IDLE;
                    end else if (replay_q) begin
                        // Re-issue the address whose data arrived during pause.
                        mem_a    = base + ADDR_W'(lane);
                        replay_d = 1'b0;
                    end else begin
                        buf_d[{lane, 3'b000} +: 8] = mem_din;
                        if (k_q == nbytes) begin
                            state_d   = ST_IDLE;
                            rdata_fin = buf_d;
                            done_if   = !cur_lsb_q;
                            done_lsb  = cur_lsb_q;
                        end else begin
                            mem_a = base + ADDR_W'(k_q);
                            k_d   = k_q + 3'd1;
                        end
                    end
                end
                ST_WRITE: begin
                    mem_wr   = 1'b1;
                    mem_a    = base + ADDR_W'(k_q);
                    mem_dout = 8'(lsb_wdata_q >> {k_q, 3'b000});
                    if (k_q == nbytes - 3'd1) begin
                        state_d  = ST_IDLE;
                        done_lsb = 1'b1;
                    end else begin
                        k_d = k_q + 3'd1;
                    end
                end
                ST_IO_WAIT: begin
                    if (!io_buffer_full)
                        state_d = ST_WRITE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Pending capture; flush replaces the fetch target even if one is pending.
    always_comb begin
        if_pend_d   = if_pend_q;
        if_addr_d   = if_addr_q;
        lsb_pend_d  = lsb_pend_q;
        lsb_wr_d    = lsb_wr_q;
        lsb_size_d  = lsb_size_q;
        lsb_addr_d  = lsb_addr_q;
        lsb_wdata_d = lsb_wdata_q;
        if (!pause) begin
            if (flush) begin
                if_pend_d = if_asking;
                if (if_asking)
                    if_addr_d = if_addr;
            end else begin
                if (done_if)
                    if_pend_d = 1'b0;
                if (if_asking && !if_pend_q) begin
                    if_pend_d = 1'b1;
                    if_addr_d = if_addr;
                end
            end
            if (done_lsb)
                lsb_pend_d = 1'b0;
            if (lsb_valid && !lsb_pend_q) begin
                lsb_pend_d  = 1'b1;
                lsb_wr_d    = lsb_wr;
                lsb_size_d  = lsb_size;
                lsb_addr_d  = lsb_addr;
                lsb_wdata_d = lsb_wdata;
            end
        end
    end

    // State, pending and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            k_q         <= '0;
            cur_lsb_q   <= 1'b0;
            replay_q    <= 1'b0;
            buf_q       <= '0;
            if_pend_q   <= 1'b0;
            if_addr_q   <= '0;
            lsb_pend_q  <= 1'b0;
            lsb_wr_q    <= 1'b0;
            lsb_size_q  <= '0;
            lsb_addr_q  <= '0;
            lsb_wdata_q <= '0;
            if_data_q   <= '0;
            if_ready_q  <= 1'b0;
            lsb_rdata_q <= '0;
            lsb_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            cur_lsb_q   <= cur_lsb_d;
            replay_q    <= replay_d;
            buf_q       <= buf_d;
            if_pend_q   <= if_pend_d;
            if_addr_q   <= if_addr_d;
            lsb_pend_q  <= lsb_pend_d;
            lsb_wr_q    <= lsb_wr_d;
            lsb_size_q  <= lsb_size_d;
            lsb_addr_q  <= lsb_addr_d;
            lsb_wdata_q <= lsb_wdata_d;
            if_ready_q  <= done_if;
            lsb_ready_q <= done_lsb;
            if (done_if)
                if_data_q <= rdata_fin;
            if (done_lsb && !lsb_wr_q)
                lsb_rdata_q <= rdata_fin;
        end
    end

    assign if_data   = if_data_q;
    assign if_ready  = if_ready_q;
    assign lsb_rdata = lsb_rdata_q;
    assign lsb_ready = lsb_ready_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: byte RAM model, transaction-level reference.
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        pause = 1'b0;
    logic        flush = 1'b0;
    logic        io_buffer_full = 1'b0;
    logic [7:0]  mem_din = 8'h00;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        if_asking = 1'b0;
    logic [31:0] if_addr = '0;
    logic [31:0] if_data;
    logic        if_ready;
    logic        lsb_valid = 1'b0;
    logic        lsb_wr = 1'b0;
    logic [1:0]  lsb_size = 2'b00;
    logic [31:0] lsb_addr = '0;
    logic [31:0] lsb_wdata = '0;
    logic [31:0] lsb_rdata;
    logic        lsb_ready;

    int errors = 0;
    int checks = 0;
    bit last_lsb = 1'b0;
    int unsigned seed = 0;

    mem_ctrl dut (
        .clk(clk), .rst_n(rst_n), .pause(pause), .flush(flush),
        .io_buffer_full(io_buffer_full), .mem_din(mem_din), .mem_dout(mem_dout),
        .mem_a(mem_a), .mem_wr(mem_wr), .if_asking(if_asking), .if_addr(if_addr),
        .if_data(if_data), .if_ready(if_ready), .lsb_valid(lsb_valid), .lsb_wr(lsb_wr),
        .lsb_size(lsb_size), .lsb_addr(lsb_addr), .lsb_wdata(lsb_wdata),
        .lsb_rdata(lsb_rdata), .lsb_ready(lsb_ready)
    );

    always #5 clk = ~clk;

    // Initial memory image: fixed fetch word at 0x100, hashed bytes elsewhere.
    function automatic logic [7:0] init_byte(input logic [15:0] a);
        case (a)
            16'h0100: return 8'h13;
            16'h0101: return 8'h05;
            16'h0102: return 8'h00;
            16'h0103: return 8'h00;
            default:  return 8'((({16'h0, a} ^ seed) * 32'h9E37_79B1) >> 13);
        endcase
    endfunction

    // Bus-side RAM (64 KiB, aliased) and a log of every write strobe.
    bit          ram_w [0:65535];
    logic [7:0]  ram_d [0:65535];
    logic [31:0] wa_q[$];
    logic [7:0]  wd_q[$];

    always @(posedge clk) begin
        if (mem_wr) begin
            ram_w[mem_a[15:0]] <= 1'b1;
            ram_d[mem_a[15:0]] <= mem_dout;
            wa_q.push_back(mem_a);
            wd_q.push_back(mem_dout);
        end
        mem_din <= ram_w[mem_a[15:0]] ? ram_d[mem_a[15:0]] : init_byte(mem_a[15:0]);
    end

    // Reference memory contents as seen by the architecture.
    logic [7:0] ref_ovr [int unsigned];

    function automatic logic [7:0] ref_byte(input logic [31:0] a);
        int unsigned key;
        key = a & 32'hFFFF;
        if (ref_ovr.exists(key))
            return ref_ovr[key];
        return init_byte(a[15:0]);
    endfunction

    function automatic logic [31:0] ref_word(input logic [31:0] a, input int n);
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < n; i++)
            v[8*i +: 8] = ref_byte(a + 32'(i));
        return v;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic check_all_zero(input string pfx);
        check({pfx, "_mem_a"},     mem_a,     32'h0);
        check({pfx, "_mem_dout"},  {24'h0, mem_dout}, 32'h0);
        check({pfx, "_mem_wr"},    {31'h0, mem_wr},   32'h0);
        check({pfx, "_if_data"},   if_data,   32'h0);
        check({pfx, "_if_ready"},  {31'h0, if_ready}, 32'h0);
        check({pfx, "_lsb_rdata"}, lsb_rdata, 32'h0);
        check({pfx, "_lsb_ready"}, {31'h0, lsb_ready}, 32'h0);
    endtask

    // One fetch and/or one LSB access issued together; the reference
    // predicts grant order, ready cycles (relative to the request cycle),
    // returned data and the exact write-strobe sequence.
    task automatic run_pair(input string tag, input bit do_if, input logic [31:0] ia,
                            input bit do_lsb, input bit wr, input logic [1:0] sz,
                            input logic [31:0] la, input logic [31:0] wd);
        int n_l, lat_l, exp_if, exp_l, t_if, t_l, cnt_if, cnt_l, w0, nw;
        bit lsb_first;
        logic [31:0] e_if, e_l, got_if, got_l;
        n_l   = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        lat_l = wr ? n_l : n_l + 1;
`ifdef MEM_CTRL_FAIR_EN
        lsb_first = !last_lsb;
`else
        lsb_first = 1'b1;
`endif
        exp_if = 0;
        exp_l  = 0;
        if (do_if && do_lsb) begin
            if (lsb_first) begin
                exp_l  = 1 + lat_l;
                exp_if = exp_l + 5;
            end else begin
                exp_if = 1 + 5;
                exp_l  = exp_if + lat_l;
            end
            last_lsb = !lsb_first;
        end else if (do_if) begin
            exp_if   = 6;
            last_lsb = 1'b0;
        end else begin
            exp_l    = 1 + lat_l;
            last_lsb = 1'b1;
        end
        e_if = ref_word(ia, 4);
        e_l  = ref_word(la, n_l);
        w0   = wa_q.size();

        @(negedge clk);
        if_asking = do_if;  if_addr  = ia;
        lsb_valid = do_lsb; lsb_wr   = wr; lsb_size = sz;
        lsb_addr  = la;     lsb_wdata = wd;
        t_if = 0; t_l = 0; cnt_if = 0; cnt_l = 0; got_if = '0; got_l = '0;
        for (int n = 1; n <= 16; n++) begin
            @(negedge clk);
            if (n == 1) begin
                if_asking = 1'b0;
                lsb_valid = 1'b0;
            end
            if (if_ready) begin
                cnt_if++;
                if (t_if == 0) begin t_if = n; got_if = if_data; end
            end
            if (lsb_ready) begin
                cnt_l++;
                if (t_l == 0) begin t_l = n; got_l = lsb_rdata; end
            end
        end

        if (do_if) begin
            check({tag, "_if_cycle"}, t_if, exp_if);
            check({tag, "_if_pulses"}, cnt_if, 1);
            check({tag, "_if_data"}, got_if, e_if);
        end else begin
            check({tag, "_if_pulses"}, cnt_if, 0);
        end
        if (do_lsb) begin
            check({tag, "_lsb_cycle"}, t_l, exp_l);
            check({tag, "_lsb_pulses"}, cnt_l, 1);
            if (!wr)
                check({tag, "_lsb_rdata"}, got_l, e_l);
        end
        nw = wa_q.size() - w0;
        if (do_lsb && wr) begin
            check({tag, "_wr_count"}, nw, n_l);
            for (int i = 0; i < n_l && i < nw; i++) begin
                check({tag, "_wr_addr"}, wa_q[w0 + i], la + 32'(i));
                check({tag, "_wr_byte"}, {24'h0, wd_q[w0 + i]}, {24'h0, wd[8*i +: 8]});
            end
            for (int i = 0; i < n_l; i++)
                ref_ovr[(la + 32'(i)) & 32'hFFFF] = wd[8*i +: 8];
        end else begin
            check({tag, "_wr_count"}, nw, 0);
        end
    endtask

    initial begin
        int t, cnt, w0, op;
        logic [31:0] got;
        seed = $urandom;

        // Reset values
        #2 rst_n = 1'b0;
        #1 check_all_zero("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Directed transactions
        run_pair("fetch_100", 1, 32'h100, 0, 0, 2'b00, 32'h0, 32'h0);
        check("fetch_100_word", if_data, 32'h0000_0513);
        run_pair("store_200", 0, 32'h0, 1, 1, 2'b10, 32'h200, 32'hDEAD_BEEF);
        run_pair("load_200", 0, 32'h0, 1, 0, 2'b10, 32'h200, 32'h0);
        run_pair("load_b", 0, 32'h0, 1, 0, 2'b00, 32'h203, 32'h0);
        run_pair("load_h", 0, 32'h0, 1, 0, 2'b01, 32'h201, 32'h0);
        run_pair("both_1", 1, 32'h1000, 1, 0, 2'b00, 32'h2000, 32'h0);
        run_pair("both_2", 1, 32'h1004, 1, 1, 2'b01, 32'h2010, 32'h0000_C3A5);
        run_pair("wrap_st", 0, 32'h0, 1, 1, 2'b01, 32'hFFFF_FFFF, 32'h0000_7E81);
        run_pair("wrap_if", 1, 32'hFFFF_FFFE, 0, 0, 2'b00, 32'h0, 32'h0);

        // Flush two cycles into a fetch, redirect to 0x40 in the same cycle
        @(negedge clk); if_asking = 1'b1; if_addr = 32'h100;
        @(negedge clk); if_asking = 1'b0;
        @(negedge clk);
        @(negedge clk); flush = 1'b1; if_asking = 1'b1; if_addr = 32'h40;
        t = 0; cnt = 0; got = '0;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            if (n == 1) begin flush = 1'b0; if_asking = 1'b0; end
            if (if_ready) begin
                cnt++;
                if (t == 0) begin t = n; got = if_data; end
            end
        end
        check("flush_cycle", t, 6);
        check("flush_pulses", cnt, 1);
        check("flush_data", got, ref_word(32'h40, 4));
        last_lsb = 1'b0;

        // IO store held off by io_buffer_full for three cycles
        w0 = wa_q.size();
        @(negedge clk);
        io_buffer_full = 1'b1;
        lsb_valid = 1'b1; lsb_wr = 1'b1; lsb_size = 2'b00;
        lsb_addr = 32'h0003_0000; lsb_wdata = 32'h0000_005A;
        t = 0; cnt = 0;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            if (n == 1) lsb_valid = 1'b0;
            if (n == 3) begin
                check("io_wait_no_wr", wa_q.size() - w0, 0);
                io_buffer_full = 1'b0;
            end
            if (lsb_ready) begin
                cnt++;
                if (t == 0) t = n;
            end
        end
        check("io_cycle", t, 5);
        check("io_pulses", cnt, 1);
        check("io_wr_count", wa_q.size() - w0, 1);
        if (wa_q.size() > w0) begin
            check("io_wr_addr", wa_q[w0], 32'h0003_0000);
            check("io_wr_byte", {24'h0, wd_q[w0]}, 32'h5A);
        end
        ref_ovr[32'h0] = 8'h5A;
        last_lsb = 1'b1;

        // Two-cycle pause mid-fetch costs two cycles plus one re-issue
        @(negedge clk); if_asking = 1'b1; if_addr = 32'h1100;
        t = 0; cnt = 0; got = '0;
        for (int n = 1; n <= 16; n++) begin
            @(negedge clk);
            if (n == 1) if_asking = 1'b0;
            if (n == 3) pause = 1'b1;
            if (n == 5) pause = 1'b0;
            if (if_ready) begin
                cnt++;
                if (t == 0) begin t = n; got = if_data; end
            end
        end
        check("pause_cycle", t, 9);
        check("pause_pulses", cnt, 1);
        check("pause_data", got, ref_word(32'h1100, 4));
        last_lsb = 1'b0;

        // Reset asserted in the middle of a fetch
        @(negedge clk); if_asking = 1'b1; if_addr = 32'h1200;
        @(negedge clk); if_asking = 1'b0;
        @(negedge clk);
        @(negedge clk); rst_n = 1'b0;
        #1 check_all_zero("midrst");
        @(negedge clk);
        @(negedge clk); rst_n = 1'b1;
        cnt = 0;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (if_ready || lsb_ready) cnt++;
        end
        check("midrst_no_stale", cnt, 0);
        last_lsb = 1'b0;
        run_pair("after_rst", 1, 32'h1200, 0, 0, 2'b00, 32'h0, 32'h0);

        // Randomized mix
        for (int i = 0; i < 24; i++) begin
            op = int'($urandom_range(0, 3));
            case (op)
                0: run_pair("rnd_if", 1, 32'h1000 + $urandom_range(0, 255), 0, 0, 2'b00, 32'h0, 32'h0);
                1: run_pair("rnd_ld", 0, 32'h0, 1, 0, 2'($urandom_range(0, 3)),
                            32'h2000 + $urandom_range(0, 63), 32'h0);
                2: run_pair("rnd_st", 0, 32'h0, 1, 1, 2'($urandom_range(0, 3)),
                            32'h2000 + $urandom_range(0, 63), $urandom);
                default: run_pair("rnd_both", 1, 32'h1000 + $urandom_range(0, 255), 1,
                                  1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                                  32'h2000 + $urandom_range(0, 63), $urandom);
            endcase
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
